stopwatch_timer: RTL and testbench

Free-running/pausable elapsed-time source for the stopwatch display path. Divides the system clock into a fixed tick rate, counts ticks into a 39-bit elapsed-time value, and handles start/stop, lap-freeze and clear from raw push-buttons. Its `time_out` bus drives the downstream blinker (bit 8 gates its blink rate) and the display formatter.

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/stopwatch_timer_button_pulse.sv | 56 +++++
 rtl/stopwatch_timer.sv | 148 ++++++++++++++
 tb/tb_stopwatch_timer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding, time width and helpers for the
//               stopwatch elapsed-time source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int TIME_W = 39;
    localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RUN_LAP   = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_PAUSE_LAP = 3'd4
    } state_t;

    function automatic logic is_running(input state_t s);
        return (s == ST_RUN) || (s == ST_RUN_LAP);
    endfunction

    function automatic logic is_lap(input state_t s);
        return (s == ST_RUN_LAP) || (s == ST_PAUSE_LAP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_timer_button_pulse.sv
// ============================================================================
// Module      : button_pulse
// Description : Synchronises and debounces one raw push-button and emits a
//               single-cycle pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pulse;

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_pulse <= 1'b0;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt    <= '0;
                r_stable <= r_sync;
                r_pulse  <= r_sync;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/stopwatch_timer.sv
// ============================================================================
// Module      : stopwatch_timer
// Description : Button-controlled elapsed-time counter with lap freeze,
//               saturating 39-bit count and fixed-rate tick prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 1000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_lap,
    input  logic              btn_clear,
    output logic [TIME_W-1:0] time_out,
    output logic              running,
    output logic              lap_active,
    output logic              tick
);

    localparam int c_div   = CLK_HZ / TICK_HZ;
    localparam int c_psc_w = $clog2(c_div);
    localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(c_div - 1);
    localparam logic [c_psc_w-1:0] c_psc_one  = c_psc_w'(1);
    localparam logic [TIME_W-1:0]  c_time_one = TIME_W'(1);

    logic [2:0] w_btn_raw;
    logic [2:0] w_btn_pulse;
    logic       w_start;
    logic       w_lap;
    logic       w_clear;

    assign w_btn_raw = {btn_clear, btn_lap, btn_start};
    assign w_start   = w_btn_pulse[0];
    assign w_lap     = w_btn_pulse[1];
    assign w_clear   = w_btn_pulse[2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        button_pulse #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_button_pulse (
            .clk    (clk),
            .rst    (reset),
            .i_btn  (w_btn_raw[gi]),
            .o_pulse(w_btn_pulse[gi])
        );
    end

    state_t              r_state;
    logic [c_psc_w-1:0]  r_psc;
    logic [TIME_W-1:0]   r_count;
    logic [TIME_W-1:0]   r_snap;
    logic [TIME_W-1:0]   r_time_out;
    logic                r_running;
    logic                r_lap_active;
    logic                r_tick;

    state_t              w_state_nxt;
    logic                w_wrap;
    logic                w_to_idle;
    logic                w_lap_enter;
    logic [c_psc_w-1:0]  w_psc_nxt;
    logic [TIME_W-1:0]   w_count_nxt;
    logic [TIME_W-1:0]   w_snap_nxt;

    // Priority clear > start > lap; pulses not valid in a state are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_start)    w_state_nxt = ST_PAUSE;
                else if (w_lap) w_state_nxt = ST_RUN_LAP;
            end
            ST_RUN_LAP: begin
                if (w_start)    w_state_nxt = ST_PAUSE_LAP;
                else if (w_lap) w_state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (w_clear)      w_state_nxt = ST_IDLE;
                else if (w_start) w_state_nxt = ST_RUN;
            end
            ST_PAUSE_LAP: begin
                if (w_clear)      w_state_nxt = ST_IDLE;
                else if (w_start) w_state_nxt = ST_RUN_LAP;
                else if (w_lap)   w_state_nxt = ST_PAUSE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters are already zero while idle, so zeroing on any IDLE-bound edge is a clear.
    always_comb begin
        w_wrap      = is_running(r_state) && (r_psc == c_psc_last);
        w_to_idle   = (w_state_nxt == ST_IDLE);
        w_lap_enter = is_lap(w_state_nxt) && !is_lap(r_state);

        w_psc_nxt = r_psc;
        if (w_to_idle || w_wrap)     w_psc_nxt = '0;
        else if (is_running(r_state)) w_psc_nxt = r_psc + c_psc_one;

        w_count_nxt = r_count;
        if (w_to_idle)                          w_count_nxt = '0;
        else if (w_wrap && r_count != TIME_MAX) w_count_nxt = r_count + c_time_one;

        w_snap_nxt = r_snap;
        if (w_to_idle)        w_snap_nxt = '0;
        else if (w_lap_enter) w_snap_nxt = w_count_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_psc        <= '0;
            r_count      <= '0;
            r_snap       <= '0;
            r_time_out   <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_psc        <= w_psc_nxt;
            r_count      <= w_count_nxt;
            r_snap       <= w_snap_nxt;
            r_time_out   <= is_lap(w_state_nxt) ? w_snap_nxt : w_count_nxt;
            r_running    <= is_running(w_state_nxt);
            r_lap_active <= is_lap(w_state_nxt);
            r_tick       <= w_wrap;
        end
    end

    assign time_out   = r_time_out;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign tick       = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
// ============================================================================
// Module      : tb_stopwatch_timer
// Description : Self-checking bench for stopwatch_timer (DIV=4, debounce=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_timer;

    localparam logic [38:0] c_max = {39{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [38:0] time_out;
    logic        running;
    logic        lap_active;
    logic        tick;

    int total = 0;
    int bad = 0;
    logic [38:0] exp_q[$];

    stopwatch_timer #(
        .CLK_HZ(4000),
        .TICK_HZ(1000),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_lap(btn_lap),
        .btn_clear(btn_clear),
        .time_out(time_out),
        .running(running),
        .lap_active(lap_active),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        total++; if (time_out !== 39'd0) begin bad++; $display("FAIL reset_time_out got=%0d exp=0", time_out); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap_active got=%b exp=0", lap_active); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        reset = 1'b0;
    endtask

    task automatic test_start();
        int n;
        int first;
        logic [38:0] e;
        btn_start = 1'b1;
        step(5);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL start_early got=%b exp=0", running); end
        step(1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%b exp=1", running); end
        for (int k = 1; k <= 5; k++) exp_q.push_back(39'(k));
        n = 0;
        first = -1;
        while (exp_q.size() > 0 && n < 40) begin
            step(1);
            n++;
            if (n == 4) btn_start = 1'b0;
            if (tick === 1'b1) begin
                if (first < 0) first = n;
                e = exp_q.pop_front();
                total++; if (time_out !== e) begin bad++; $display("FAIL start_count got=%0d exp=%0d", time_out, e); end
            end
        end
        total++; if (first !== 4) begin bad++; $display("FAIL start_first_tick got=%0d exp=4", first); end
        total++; if (n !== 20 || exp_q.size() != 0) begin bad++; $display("FAIL start_span got=%0d exp=20", n); end
        exp_q.delete();
    endtask

    task automatic test_pause_resume();
        int ticks;
        btn_start = 1'b1;
        step(6);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", running); end
        total++; if (time_out !== 39'd6) begin bad++; $display("FAIL pause_value got=%0d exp=6", time_out); end
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i == 3) btn_start = 1'b0;
            if (tick === 1'b1) ticks++;
        end
        total++; if (ticks !== 0 || time_out !== 39'd6) begin bad++; $display("FAIL pause_frozen got=%0d ticks=%0d exp=6 ticks=0", time_out, ticks); end
        btn_start = 1'b1;
        step(6);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b exp=1", running); end
        step(1);
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL resume_early_tick got=%b exp=0", tick); end
        step(1);
        total++; if (tick !== 1'b1 || time_out !== 39'd7) begin bad++; $display("FAIL resume_tick got=%b/%0d exp=1/7", tick, time_out); end
        step(2);
        btn_start = 1'b0;
    endtask

    task automatic test_lap();
        int n;
        logic [38:0] e;
        btn_lap = 1'b1;
        step(5);
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_early got=%b exp=0", lap_active); end
        step(1);
        total++; if (lap_active !== 1'b1 || time_out !== 39'd9 || tick !== 1'b1) begin bad++; $display("FAIL lap_snapshot_edge got=%b/%0d/%b exp=1/9/1", lap_active, time_out, tick); end
        step(2);
        btn_lap = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(39'd9);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1);
            n++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (time_out !== e) begin bad++; $display("FAIL lap_frozen got=%0d exp=%0d", time_out, e); end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lap_tick_timeout got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        btn_lap = 1'b1;
        step(5);
        total++; if (lap_active !== 1'b1 || time_out !== 39'd9) begin bad++; $display("FAIL lap_hold got=%b/%0d exp=1/9", lap_active, time_out); end
        step(1);
        total++; if (lap_active !== 1'b0 || time_out !== 39'd13) begin bad++; $display("FAIL lap_release got=%b/%0d exp=0/13", lap_active, time_out); end
        step(2);
        btn_lap = 1'b0;
    endtask

    task automatic test_clear_rules();
        btn_clear = 1'b1;
        step(6);
        total++; if (running !== 1'b1 || time_out !== 39'd15) begin bad++; $display("FAIL clear_in_run got=%b/%0d exp=1/15", running, time_out); end
        step(2);
        btn_clear = 1'b0;
        btn_lap = 1'b1;
        step(6);
        total++; if (lap_active !== 1'b1 || time_out !== 39'd17) begin bad++; $display("FAIL clear_lap_enter got=%b/%0d exp=1/17", lap_active, time_out); end
        step(2);
        btn_lap = 1'b0;
        btn_start = 1'b1;
        step(6);
        total++; if (running !== 1'b0 || lap_active !== 1'b1 || time_out !== 39'd17) begin bad++; $display("FAIL pause_lap got=%b/%b/%0d exp=0/1/17", running, lap_active, time_out); end
        step(2);
        btn_start = 1'b0;
        btn_clear = 1'b1;
        step(6);
        total++; if (time_out !== 39'd0 || lap_active !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL clear_pause_lap got=%0d/%b/%b exp=0/0/0", time_out, lap_active, running); end
        step(2);
        btn_clear = 1'b0;
        btn_start = 1'b1;
        step(8);
        btn_start = 1'b0;
        step(8);
        btn_start = 1'b1;
        step(6);
        total++; if (running !== 1'b0 || time_out !== 39'd4) begin bad++; $display("FAIL clear_setup_pause got=%b/%0d exp=0/4", running, time_out); end
        step(2);
        btn_start = 1'b0;
        step(6);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step(6);
        total++; if (running !== 1'b0 || time_out !== 39'd0) begin bad++; $display("FAIL clear_beats_start got=%b/%0d exp=0/0", running, time_out); end
        step(2);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(6);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL clear_start_dropped got=%b exp=0", running); end
    endtask

    task automatic test_debounce();
        int early;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            btn_start = ((i % 4) < 2);
            step(1);
            if (running === 1'b1) early++;
        end
        btn_start = 1'b1;
        step(5);
        total++; if (early !== 0 || running !== 1'b0) begin bad++; $display("FAIL bounce_early got=%0d/%b exp=0/0", early, running); end
        step(1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL bounce_accept got=%b exp=1", running); end
        step(10);
        btn_start = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL bounce_single got=%b exp=1", running); end
        step(8);
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(10);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL glitch_ignored got=%b exp=1", running); end
    endtask

    task automatic test_saturation_reset();
        int n;
        logic [38:0] e;
        n = 0;
        step(1);
        while (tick !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        force dut.r_count = c_max - 39'd1;
        step(1);
        release dut.r_count;
        for (int k = 0; k < 3; k++) exp_q.push_back(c_max);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1);
            n++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (time_out !== e) begin bad++; $display("FAIL sat_value got=%0d exp=%0d", time_out, e); end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sat_tick_timeout got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        btn_lap = 1'b1;
        step(3);
        reset = 1'b1;
        btn_lap = 1'b0;
        step(1);
        reset = 1'b0;
        total++; if (time_out !== 39'd0 || running !== 1'b0 || lap_active !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL midreset_outputs got=%0d/%b/%b/%b exp=0/0/0/0", time_out, running, lap_active, tick); end
        step(10);
        total++; if (lap_active !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL midreset_no_pulse got=%b/%b exp=0/0", lap_active, running); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_resume();
        test_lap();
        test_clear_rules();
        test_debounce();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
